// File: rtl/fetch_decode_insn_queue.sv
// Instruction queue between fetch and decode: multi-lane circular buffer with
// group pop on decode completion, plus decode-redirect and backend flush.
module fetch_decode_insn_queue #(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PC_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FETCH_WIDTH-1:0]           in_valid,
  input  logic [FETCH_WIDTH*32-1:0]        in_insn,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]  in_pc,
  input  logic [FETCH_WIDTH-1:0]           in_pred_taken,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]  in_pred_addr,
  output logic                             in_ready,
  output logic [DECODE_WIDTH-1:0]          out_valid,
  output logic [DECODE_WIDTH*32-1:0]       out_insn,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0] out_pc,
  output logic [DECODE_WIDTH-1:0]          out_pred_taken,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0] out_pred_addr,
  input  logic                             decode_stall,
  input  logic                             decode_complete,
  input  logic                             dec_flush,
  input  logic                             backend_flush,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int unsigned InsnW = 32;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  // Largest occupancy that still leaves room for a full fetch group.
  localparam logic [CntW-1:0] ReadyLimit = CntW'(DEPTH - FETCH_WIDTH);

  logic [InsnW-1:0]    insnMem  [DEPTH];
  logic [PC_WIDTH-1:0] pcMem    [DEPTH];
  logic                takenMem [DEPTH];
  logic [PC_WIDTH-1:0] addrMem  [DEPTH];

  logic [PtrW-1:0]         head, tail, headNext, tailNext;
  logic [CntW-1:0]         countNext, pushCnt, popCnt;
  logic                    fire, writeEn, inReadyNext;
  logic [DECODE_WIDTH-1:0] outValidNext;

  // Push/pop sizes for this cycle; in_ready and out_valid are registered.
  always_comb begin
    pushCnt = '0;
    popCnt  = '0;
    fire    = decode_complete && !decode_stall;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (in_ready && in_valid[i]) pushCnt = pushCnt + CntW'(1);
    end
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      if (fire && out_valid[i]) popCnt = popCnt + CntW'(1);
    end
  end

  // Next pointers/occupancy; backend flush wins over a decode redirect.
  always_comb begin
    headNext  = head + PtrW'(popCnt);
    tailNext  = tail + PtrW'(pushCnt);
    countNext = count - popCnt + pushCnt;
    writeEn   = 1'b1;
    if (backend_flush) begin
      headNext  = tail;
      tailNext  = tail;
      countNext = '0;
      writeEn   = 1'b0;
    end else if (fire && dec_flush) begin
      tailNext  = headNext;
      countNext = '0;
      writeEn   = 1'b0;
    end
    inReadyNext = countNext <= ReadyLimit;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      outValidNext[i] = countNext > CntW'(i);
    end
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= '0;
    end else begin
      head      <= headNext;
      tail      <= tailNext;
      count     <= countNext;
      in_ready  <= inReadyNext;
      out_valid <= outValidNext;
    end
  end

  // Entry storage: accepted lanes land at tail..tail+push-1 in lane order.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (writeEn && in_ready && in_valid[i]) begin
        insnMem[tail + PtrW'(i)]  <= in_insn[InsnW*i +: InsnW];
        pcMem[tail + PtrW'(i)]    <= in_pc[PC_WIDTH*i +: PC_WIDTH];
        takenMem[tail + PtrW'(i)] <= in_pred_taken[i];
        addrMem[tail + PtrW'(i)]  <= in_pred_addr[PC_WIDTH*i +: PC_WIDTH];
      end
    end
  end

  // Decode lanes read the oldest entries directly from storage.
  always_comb begin
    out_insn       = '0;
    out_pc         = '0;
    out_pred_taken = '0;
    out_pred_addr  = '0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      out_insn[InsnW*i +: InsnW]       = insnMem[head + PtrW'(i)];
      out_pc[PC_WIDTH*i +: PC_WIDTH]   = pcMem[head + PtrW'(i)];
      out_pred_taken[i]                = takenMem[head + PtrW'(i)];
      out_pred_addr[PC_WIDTH*i +: PC_WIDTH] = addrMem[head + PtrW'(i)];
    end
  end

  // Interface sanity checks.
  assert property (@(posedge clk) disable iff (rst)
    (in_valid & FETCH_WIDTH'(in_valid + 1'b1)) == '0);
  assert property (@(posedge clk) disable iff (rst) count <= CntW'(DEPTH));
  assert property (@(posedge clk) disable iff (rst)
    !(decode_complete && (out_valid == '0)));

endmodule

// File: tb/tb_fetch_decode_insn_queue.sv
// Randomized + directed bench for fetch_decode_insn_queue with a queue-based model.
module tb_fetch_decode_insn_queue;

  localparam int FW = 2;
  localparam int DW = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] addr;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [FW-1:0]   in_valid;
  logic [FW*32-1:0] in_insn, in_pc, in_pred_addr;
  logic [FW-1:0]   in_pred_taken;
  logic            in_ready;
  logic [DW-1:0]   out_valid;
  logic [DW*32-1:0] out_insn, out_pc, out_pred_addr;
  logic [DW-1:0]   out_pred_taken;
  logic            decode_stall, decode_complete, dec_flush, backend_flush;
  logic [3:0]      count;

  int   tests = 0;
  int   fails = 0;
  ent_t q[$];

  fetch_decode_insn_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
    .in_pred_taken(in_pred_taken), .in_pred_addr(in_pred_addr),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_pred_addr(out_pred_addr),
    .decode_stall(decode_stall), .decode_complete(decode_complete),
    .dec_flush(dec_flush), .backend_flush(backend_flush),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit modelReady();
    return (DEPTH - q.size()) >= FW;
  endfunction

  // Queue-level model of one clock edge using the currently driven inputs.
  task automatic modelStep();
    int pop;
    bit rdy, fire;
    ent_t e;
    if (rst || backend_flush) begin
      q.delete();
      return;
    end
    rdy  = modelReady();
    fire = decode_complete && !decode_stall;
    pop  = fire ? ((q.size() < DW) ? q.size() : DW) : 0;
    if (fire && dec_flush) begin
      q.delete();
      return;
    end
    for (int i = 0; i < pop; i++) void'(q.pop_front());
    if (rdy) begin
      for (int i = 0; i < FW; i++) begin
        if (in_valid[i]) begin
          e.insn  = in_insn[32*i +: 32];
          e.pc    = in_pc[32*i +: 32];
          e.taken = in_pred_taken[i];
          e.addr  = in_pred_addr[32*i +: 32];
          q.push_back(e);
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkAll();
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(modelReady()));
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(q.size() > i));
      if (q.size() > i) begin
        chk($sformatf("out_insn[%0d]", i), 64'(out_insn[32*i +: 32]), 64'(q[i].insn));
        chk($sformatf("out_pc[%0d]", i), 64'(out_pc[32*i +: 32]), 64'(q[i].pc));
        chk($sformatf("out_taken[%0d]", i), 64'(out_pred_taken[i]), 64'(q[i].taken));
        chk($sformatf("out_addr[%0d]", i), 64'(out_pred_addr[32*i +: 32]), 64'(q[i].addr));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = '0; decode_stall = 1'b0; decode_complete = 1'b0;
    dec_flush = 1'b0; backend_flush = 1'b0;
  endtask

  task automatic setGroup(input int n, input logic [31:0] pc0);
    in_valid = (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
    for (int i = 0; i < FW; i++) begin
      in_insn[32*i +: 32]      = $urandom;
      in_pc[32*i +: 32]        = pc0 + 32'(4 * i);
      in_pred_taken[i]         = 1'($urandom);
      in_pred_addr[32*i +: 32] = $urandom;
    end
  endtask

  task automatic pushN(input int n, input logic [31:0] pc0);
    setGroup(n, pc0);
    cycle();
    in_valid = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    setGroup(0, 32'h0);
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset count", 64'(count), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);

    // First push visible next cycle, oldest in lane 0.
    pushN(2, 32'h100);
    chk("push2 count", 64'(count), 64'd2);
    chk("push2 out_valid", 64'(out_valid), 64'b11);
    chk("push2 out_pc", 64'(out_pc), {32'h104, 32'h100});

    // Fill to full under stall; held group not written.
    decode_stall = 1'b1;
    pushN(2, 32'h108);
    pushN(2, 32'h110);
    chk("count6 in_ready", 64'(in_ready), 64'd1);
    pushN(2, 32'h118);
    chk("full count", 64'(count), 64'd8);
    chk("full in_ready", 64'(in_ready), 64'd0);
    setGroup(2, 32'h120);
    cycle();
    cycle();
    chk("held count", 64'(count), 64'd8);
    chk("held head pc", 64'(out_pc[31:0]), 64'h100);
    idle();

    // Occupancy 7 also blocks a full group.
    backend_flush = 1'b1;
    cycle();
    idle();
    pushN(1, 32'h300);
    pushN(2, 32'h304);
    pushN(2, 32'h30c);
    pushN(2, 32'h314);
    chk("count7", 64'(count), 64'd7);
    chk("count7 in_ready", 64'(in_ready), 64'd0);
    setGroup(2, 32'h320);
    cycle();
    chk("count7 held", 64'(count), 64'd7);
    idle();

    // Wrap: head at 6, pop 6,7 while writing 0,1.
    rst = 1'b1;
    cycle();
    idle();
    pushN(2, 32'h10);
    pushN(2, 32'h18);
    pushN(2, 32'h20);
    backend_flush = 1'b1;
    cycle();
    idle();
    pushN(2, 32'h400);
    setGroup(2, 32'h500);
    decode_complete = 1'b1;
    cycle();
    idle();
    chk("wrap count", 64'(count), 64'd2);
    chk("wrap out_pc", 64'(out_pc), {32'h504, 32'h500});

    // Decode redirect drops everything including this cycle's push.
    backend_flush = 1'b1;
    cycle();
    idle();
    pushN(2, 32'h40);
    pushN(2, 32'h48);
    pushN(1, 32'h50);
    chk("pre-redirect count", 64'(count), 64'd5);
    setGroup(2, 32'h600);
    decode_complete = 1'b1;
    dec_flush = 1'b1;
    cycle();
    idle();
    chk("redirect count", 64'(count), 64'd0);
    chk("redirect in_ready", 64'(in_ready), 64'd1);
    chk("redirect out_valid", 64'(out_valid), 64'd0);

    // Backend flush overrides fire and push.
    pushN(2, 32'h60);
    pushN(2, 32'h68);
    pushN(1, 32'h70);
    setGroup(2, 32'h700);
    decode_complete = 1'b1;
    backend_flush = 1'b1;
    cycle();
    idle();
    chk("bflush count", 64'(count), 64'd0);
    pushN(1, 32'h200);
    chk("after bflush pc", 64'(out_pc[31:0]), 64'h200);
    chk("after bflush count", 64'(count), 64'd1);

    // Group held until decode_complete.
    pushN(1, 32'h204);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold count", 64'(count), 64'd2);
      chk("hold out_pc", 64'(out_pc), {32'h204, 32'h200});
    end
    decode_complete = 1'b1;
    cycle();
    idle();
    chk("pop count", 64'(count), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (modelReady() || rst) setGroup(int'($urandom_range(0, 2)), $urandom & 32'hffff_fffc);
      rst             = ($urandom_range(0, 299) == 0);
      decode_stall    = ($urandom_range(0, 3) == 0);
      decode_complete = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      dec_flush       = ($urandom_range(0, 11) == 0);
      backend_flush   = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
